// File: rtl/bru_pkg.sv
// Shared encodings and the condition evaluator for the branch resolve unit.
package bru_pkg;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_ctrl_e;

  localparam int unsigned PC_STEP = 4;

  // Returns {illegal, taken}; illegal encodings are never taken.
  function automatic logic [1:0] br_eval(input logic [2:0] ctrl, input logic eq,
                                         input logic lt_s, input logic lt_u);
    logic [1:0] r;
    r = 2'b00;
    case (ctrl)
      BR_EQ:   r = {1'b0, eq};
      BR_NE:   r = {1'b0, ~eq};
      BR_LT:   r = {1'b0, lt_s};
      BR_GE:   r = {1'b0, ~lt_s};
      BR_LTU:  r = {1'b0, lt_u};
      BR_GEU:  r = {1'b0, ~lt_u};
      default: r = 2'b10;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bru_cmp.sv
// Full-width operand comparator: equality plus signed and unsigned less-than.
module bru_cmp #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            eq_o,
  output logic            lt_s_o,
  output logic            lt_u_o
);

  assign eq_o   = (a_i == b_i);
  assign lt_s_o = ($signed(a_i) < $signed(b_i));
  assign lt_u_o = (a_i < b_i);

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: 1- or 2-stage elastic pipeline producing outcome and redirect PC.
// Optional BRU_PERF_CNT_EN adds saturating handshake / mispredict counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      br_ctrl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            pred_taken,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic            illegal
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count
`endif
);

  logic            cmp_eq, cmp_lt_s, cmp_lt_u;
  logic [XLEN-1:0] pc_tgt, pc_seq;

  bru_cmp #(.XLEN(XLEN)) u_cmp (
    .a_i    (src_a),
    .b_i    (src_b),
    .eq_o   (cmp_eq),
    .lt_s_o (cmp_lt_s),
    .lt_u_o (cmp_lt_u)
  );

  assign pc_tgt = pc + imm;
  assign pc_seq = pc + XLEN'(PC_STEP);

  // Output stage registers
  logic            out_vld_q, taken_q, mis_q, ill_q;
  logic [XLEN-1:0] rpc_q;
  logic            out_space;
  logic            stage_ready;

  // Result presented to the output stage by whatever feeds it
  logic            fwd_vld, fwd_taken, fwd_mis, fwd_ill;
  logic [XLEN-1:0] fwd_rpc;

  assign out_space = !out_vld_q || out_ready;
  assign in_ready  = flush || stage_ready;

  generate
    if (STAGES == 2) begin : g_two
      logic            s1_vld_q, s1_eq_q, s1_lts_q, s1_ltu_q, s1_pred_q;
      logic [2:0]      s1_ctrl_q;
      logic [XLEN-1:0] s1_tgt_q, s1_seq_q;
      logic [1:0]      s1_res;

      assign stage_ready = !s1_vld_q || out_space;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_vld_q  <= 1'b0;
          s1_eq_q   <= 1'b0;
          s1_lts_q  <= 1'b0;
          s1_ltu_q  <= 1'b0;
          s1_pred_q <= 1'b0;
          s1_ctrl_q <= 3'b000;
          s1_tgt_q  <= '0;
          s1_seq_q  <= '0;
        end else if (flush) begin
          s1_vld_q <= 1'b0;
        end else if (stage_ready) begin
          s1_vld_q <= in_valid;
          if (in_valid) begin
            s1_eq_q   <= cmp_eq;
            s1_lts_q  <= cmp_lt_s;
            s1_ltu_q  <= cmp_lt_u;
            s1_pred_q <= pred_taken;
            s1_ctrl_q <= br_ctrl;
            s1_tgt_q  <= pc_tgt;
            s1_seq_q  <= pc_seq;
          end
        end
      end

      assign s1_res    = br_eval(s1_ctrl_q, s1_eq_q, s1_lts_q, s1_ltu_q);
      assign fwd_vld   = s1_vld_q;
      assign fwd_ill   = s1_res[1];
      assign fwd_taken = s1_res[0];
      assign fwd_mis   = s1_res[0] ^ s1_pred_q;
      assign fwd_rpc   = s1_res[0] ? s1_tgt_q : s1_seq_q;
    end else begin : g_one
      logic [1:0] in_res;

      assign stage_ready = out_space;
      assign in_res      = br_eval(br_ctrl, cmp_eq, cmp_lt_s, cmp_lt_u);
      assign fwd_vld     = in_valid;
      assign fwd_ill     = in_res[1];
      assign fwd_taken   = in_res[0];
      assign fwd_mis     = in_res[0] ^ pred_taken;
      assign fwd_rpc     = in_res[0] ? pc_tgt : pc_seq;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      taken_q   <= 1'b0;
      mis_q     <= 1'b0;
      ill_q     <= 1'b0;
      rpc_q     <= '0;
    end else if (flush) begin
      out_vld_q <= 1'b0;
    end else if (out_space) begin
      out_vld_q <= fwd_vld;
      if (fwd_vld) begin
        taken_q <= fwd_taken;
        mis_q   <= fwd_mis;
        ill_q   <= fwd_ill;
        rpc_q   <= fwd_rpc;
      end
    end
  end

  // Flags are masked so an idle output never shows stale results
  assign out_valid   = out_vld_q;
  assign taken       = out_vld_q & taken_q;
  assign mispredict  = out_vld_q & mis_q;
  assign illegal     = out_vld_q & ill_q;
  assign redirect_pc = rpc_q;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] br_cnt_q, mis_cnt_q;
  logic        hs;

  assign hs = out_vld_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (hs) begin
      if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + 32'd1;
      if (mis_q && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign br_count      = br_cnt_q;
  assign mispred_count = mis_cnt_q;
`endif

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter XLEN, default 32: operand and PC width; legal values 32 or 64.
REQ-002 Parameter STAGES, default 2: pipeline depth; legal values 1 or 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  unit accepts a request this cycle.
REQ-007 br_ctrl  input  3  condition: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 illegal.
REQ-008 src_a, src_b  input  XLEN  compare operands.
REQ-009 pc, imm  input  XLEN  branch PC and sign-extended offset.
REQ-010 pred_taken  input  1  front-end prediction for this branch.
REQ-011 flush  input  1  synchronous kill of all in-flight requests.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 taken  output  1  resolved branch outcome.
REQ-015 mispredict  output  1  taken != pred_taken, or illegal br_ctrl with pred_taken=1.
REQ-016 redirect_pc  output  XLEN  pc+imm when taken, else pc+4.
REQ-017 illegal  output  1  br_ctrl was 010 or 011.

Function
REQ-018 Compare SHALL be full-width: signed compare for LT/GE, unsigned for LTU/GEU; GE = not LT; NE = not EQ.
REQ-019 Illegal br_ctrl SHALL force taken=0 and illegal=1.
REQ-020 Adds SHALL be modulo 2^XLEN; wrap-around is not flagged.
REQ-021 Latency SHALL be exactly STAGES cycles from accepted input to out_valid when no back-pressure is present.
REQ-022 STAGES=2: stage 1 registers compare flags and both candidate PCs; stage 2 registers the selected result.
REQ-023 Each stage SHALL hold its contents while its downstream is not ready.
REQ-024 in_ready SHALL equal (first stage empty) OR (first stage advancing this cycle); full throughput is one request per cycle.
REQ-025 Output fields SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 flush SHALL clear every stage valid on the next edge and SHALL override any acceptance in the same cycle; in_ready stays 1 during flush.
REQ-027 When out_valid=0, taken/mispredict/illegal SHALL read 0; redirect_pc is don't-care.

Reset
REQ-028 On rst_n low, all stage valids, out_valid, taken, mispredict, illegal and redirect_pc SHALL go to 0 immediately, regardless of clk.
REQ-029 Reset asserted mid-transfer SHALL drop in-flight requests; after reset release, in_ready=1 on the first clock edge.

Configuration
REQ-030 With BRU_PERF_CNT_EN defined: 32-bit outputs br_count and mispred_count SHALL increment on each out_valid&&out_ready handshake (mispred_count only if mispredict=1), SHALL saturate at all-ones and SHALL reset to 0.
REQ-031 Without BRU_PERF_CNT_EN: the counter ports and logic SHALL be absent.

Structure
REQ-032 Package bru_pkg SHALL hold the br_ctrl encoding enum (BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU) and the constant PC_STEP=4.
REQ-033 Sub-module bru_cmp (combinational XLEN compare producing eq, lt_s, lt_u) SHALL be instantiated once.

Verification
REQ-034 The bench SHALL cover: BR_LT with src_a=0xFFFFFFFF, src_b=1 -> taken=1; BR_LTU with the same operands -> taken=0.
REQ-035 The bench SHALL cover: BR_EQ with a=b=5, pc=0x100, imm=0x20, pred_taken=0 -> taken=1, mispredict=1, redirect_pc=0x120, exactly STAGES cycles later.
REQ-036 The bench SHALL cover: br_ctrl=010 with pred_taken=1 -> illegal=1, taken=0, mispredict=1, redirect_pc=pc+4.
REQ-037 The bench SHALL cover: a back-to-back stream of 8 requests with out_ready held low for 3 cycles -> no loss or duplication, outputs held stable, in_ready deasserts once all stages are full.
REQ-038 The bench SHALL cover: flush asserted with 2 requests in flight plus a concurrent in_valid -> next cycle out_valid=0 and no result ever emerges.
REQ-039 The bench SHALL cover: with BRU_PERF_CNT_EN defined, 3 branches of which 1 mispredicts -> br_count=3, mispred_count=1; an rst_n pulse returns both counters to 0.
